// File: rtl/build_info_pkg.sv
// build_info_pkg
// Shared definitions for the build-info frame transmitter: the frame FSM
// state type, the default frame start marker, per-source field sizes,
// byte-index landmarks inside a source record, the frame-length function
// and the running checksum helper.
package build_info_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SYNC  = 3'd1,
        COUNT = 3'd2,
        IDX   = 3'd3,
        HASH  = 3'd4,
        TS    = 3'd5,
        CSUM  = 3'd6
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         HASH_BYTES        = 32'sd8;
    localparam int         TS_BYTES          = 32'sd4;

    // Byte index inside one source record: 0..7 hash bytes, 8..11 timestamp bytes.
    localparam logic [3:0] HASH_LAST = 4'd7;
    localparam logic [3:0] TS_FIRST  = 4'd8;
    localparam logic [3:0] TS_LAST   = 4'd11;

    // Sync + count + per source (index + hash + timestamp) + checksum.
    function automatic int frame_len(input int num_src);
        return num_src * (HASH_BYTES + TS_BYTES + 32'sd1) + 32'sd3;
    endfunction

    // Modulo-256 accumulation of one transmitted byte.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/build_info_snap.sv
// build_info_snap
// Snapshot register bank for all build-info sources, captured on frame
// start so that input changes mid-frame never leak into a frame, plus a
// byte-select mux addressed by source index and record byte index.
// Ports:
//   clk100, rst       - clock, synchronous active-high reset
//   load_i            - capture all sources this cycle
//   git_hash_i        - NUM_SRC x 64-bit git hashes
//   timestamp_i       - NUM_SRC x 32-bit build timestamps
//   src_sel_i         - source index to read
//   byte_sel_i        - record byte: 0..7 hash MSB first, 8..11 timestamp MSB first
//   byte_o            - selected snapshot byte (combinational)
module build_info_snap
    import build_info_pkg::*;
#(
    parameter int NUM_SRC = 4
) (
    input  logic                     clk100,
    input  logic                     rst,
    input  logic                     load_i,
    input  logic [NUM_SRC-1:0][63:0] git_hash_i,
    input  logic [NUM_SRC-1:0][31:0] timestamp_i,
    input  logic [3:0]               src_sel_i,
    input  logic [3:0]               byte_sel_i,
    output logic [7:0]               byte_o
);

    logic [NUM_SRC-1:0][63:0] hash_r;
    logic [NUM_SRC-1:0][31:0] ts_r;
    logic [63:0]              hash_sel_s;
    logic [31:0]              ts_sel_s;

    // Capture every source when a frame is accepted.
    always_ff @(posedge clk100) begin
        if (rst) begin
            hash_r <= '0;
            ts_r   <= '0;
        end else if (load_i) begin
            hash_r <= git_hash_i;
            ts_r   <= timestamp_i;
        end
    end

    // AND-OR source mux; indices beyond NUM_SRC-1 read as zero.
    always_comb begin
        hash_sel_s = 64'h0;
        ts_sel_s   = 32'h0;
        for (int i = 0; i < NUM_SRC; i++) begin
            hash_sel_s = hash_sel_s | ({64{src_sel_i == 4'(i)}} & hash_r[i]);
            ts_sel_s   = ts_sel_s   | ({32{src_sel_i == 4'(i)}} & ts_r[i]);
        end
    end

    // Pick the record byte, most significant byte first within each field.
    always_comb begin
        case (byte_sel_i)
            4'd0:    byte_o = hash_sel_s[63:56];
            4'd1:    byte_o = hash_sel_s[55:48];
            4'd2:    byte_o = hash_sel_s[47:40];
            4'd3:    byte_o = hash_sel_s[39:32];
            4'd4:    byte_o = hash_sel_s[31:24];
            4'd5:    byte_o = hash_sel_s[23:16];
            4'd6:    byte_o = hash_sel_s[15:8];
            4'd7:    byte_o = hash_sel_s[7:0];
            4'd8:    byte_o = ts_sel_s[31:24];
            4'd9:    byte_o = ts_sel_s[23:16];
            4'd10:   byte_o = ts_sel_s[15:8];
            4'd11:   byte_o = ts_sel_s[7:0];
            default: byte_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/build_info_tx.sv
// build_info_tx
// Serialises the build information of NUM_SRC sources into one byte frame
// for a UART transmitter: SYNC_BYTE, NUM_SRC, then per source the index,
// 8 hash bytes and 4 timestamp bytes (MSB first), then a modulo-256
// checksum of every byte after SYNC_BYTE. Sits between the user_init
// sources and the UART click transmitter.
// Ports:
//   clk100, rst            - clock, synchronous active-high reset
//   git_hash_i/timestamp_i - per-source build info (0 scripts, 1 top, 2 uart, 3 lcd)
//   start_i                - one-cycle frame request, ignored while busy
//   tx_data_o/tx_valid_o   - byte stream, held stable until tx_ready_i
//   tx_ready_i             - transmitter accepts the byte
//   busy_o                 - frame in progress
//   done_o                 - one-cycle pulse after the checksum handshake
//   frame_cnt_o            - completed frames, wrapping
module build_info_tx
    import build_info_pkg::*;
#(
    parameter int         NUM_SRC   = 4,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic                     clk100,
    input  logic                     rst,
    input  logic [NUM_SRC-1:0][63:0] git_hash_i,
    input  logic [NUM_SRC-1:0][31:0] timestamp_i,
    input  logic                     start_i,
    output logic [7:0]               tx_data_o,
    output logic                     tx_valid_o,
    input  logic                     tx_ready_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [15:0]              frame_cnt_o
);

    localparam logic [3:0] LAST_SRC  = 4'(NUM_SRC - 1);
    localparam logic [7:0] SRC_COUNT = 8'(NUM_SRC);

    state_t      state_r, state_next_s;
    logic [3:0]  src_r, src_next_s;
    logic [3:0]  byte_r, byte_next_s;
    logic [7:0]  csum_r, csum_next_s;
    logic [7:0]  data_r, data_next_s;
    logic        valid_r, busy_r, done_r, done_next_s;
    logic [15:0] frame_cnt_r;
    logic        hs_s, load_s;
    logic [7:0]  snap_byte_s;

    assign hs_s   = valid_r & tx_ready_i;
    // Only IDLE accepts a start, which also drops a start coinciding with the checksum handshake.
    assign load_s = (state_r == IDLE) & start_i;

    // The mux is addressed with the next counters so the byte is ready as a registered output.
    build_info_snap #(
        .NUM_SRC (NUM_SRC)
    ) u_snap (
        .clk100      (clk100),
        .rst         (rst),
        .load_i      (load_s),
        .git_hash_i  (git_hash_i),
        .timestamp_i (timestamp_i),
        .src_sel_i   (src_next_s),
        .byte_sel_i  (byte_next_s),
        .byte_o      (snap_byte_s)
    );

    // Next state, source index and record byte index; advance only on handshake.
    always_comb begin
        state_next_s = state_r;
        src_next_s   = src_r;
        byte_next_s  = byte_r;
        done_next_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    state_next_s = SYNC;
                    src_next_s   = 4'd0;
                    byte_next_s  = 4'd0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SYNC: begin
                if (hs_s) state_next_s = COUNT;
                else      state_next_s = SYNC;
            end
            COUNT: begin
                if (hs_s) state_next_s = IDX;
                else      state_next_s = COUNT;
            end
            IDX: begin
                if (hs_s) begin
                    state_next_s = HASH;
                    byte_next_s  = 4'd0;
                end else begin
                    state_next_s = IDX;
                end
            end
            HASH: begin
                if (hs_s) begin
                    if (byte_r == HASH_LAST) begin
                        state_next_s = TS;
                        byte_next_s  = TS_FIRST;
                    end else begin
                        byte_next_s  = byte_r + 4'd1;
                    end
                end else begin
                    state_next_s = HASH;
                end
            end
            TS: begin
                if (hs_s) begin
                    if (byte_r == TS_LAST) begin
                        if (src_r == LAST_SRC) begin
                            state_next_s = CSUM;
                        end else begin
                            state_next_s = IDX;
                            src_next_s   = src_r + 4'd1;
                        end
                    end else begin
                        byte_next_s = byte_r + 4'd1;
                    end
                end else begin
                    state_next_s = TS;
                end
            end
            CSUM: begin
                if (hs_s) begin
                    state_next_s = IDLE;
                    done_next_s  = 1'b1;
                end else begin
                    state_next_s = CSUM;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Next outgoing byte; the checksum accumulates each byte as it is loaded.
    always_comb begin
        data_next_s = data_r;
        csum_next_s = csum_r;
        if (load_s) begin
            data_next_s = SYNC_BYTE;
            csum_next_s = 8'h00;
        end else if (hs_s) begin
            case (state_next_s)
                COUNT: begin
                    data_next_s = SRC_COUNT;
                    csum_next_s = csum_add(csum_r, SRC_COUNT);
                end
                IDX: begin
                    data_next_s = {4'h0, src_next_s};
                    csum_next_s = csum_add(csum_r, {4'h0, src_next_s});
                end
                HASH, TS: begin
                    data_next_s = snap_byte_s;
                    csum_next_s = csum_add(csum_r, snap_byte_s);
                end
                CSUM:    data_next_s = csum_r;
                default: data_next_s = 8'h00;
            endcase
        end else begin
            data_next_s = data_r;
        end
    end

    // Frame sequencer and registered stream outputs.
    always_ff @(posedge clk100) begin
        if (rst) begin
            state_r <= IDLE;
            src_r   <= 4'd0;
            byte_r  <= 4'd0;
            csum_r  <= 8'h00;
            data_r  <= 8'h00;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            src_r   <= src_next_s;
            byte_r  <= byte_next_s;
            csum_r  <= csum_next_s;
            data_r  <= data_next_s;
            valid_r <= (state_next_s != IDLE);
            busy_r  <= (state_next_s != IDLE);
            done_r  <= done_next_s;
        end
    end

    // Completed-frame counter, wrapping naturally at 16 bits.
    always_ff @(posedge clk100) begin
        if (rst) begin
            frame_cnt_r <= 16'h0000;
        end else if (done_next_s) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
        end
    end

    assign tx_data_o   = data_r;
    assign tx_valid_o  = valid_r;
    assign busy_o      = busy_r;
    assign done_o      = done_r;
    assign frame_cnt_o = frame_cnt_r;

endmodule
